// File: rtl/gaze_sched_pkg.sv
// Shared types and constants for the gaze level scheduler.
// Holds FSM states, level codes, field widths and the level compare.
package gaze_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT
    } state_t;

    localparam int COORD_W = 11;
    localparam int THRES_W = 24;
    localparam int SUM_W   = 25;

    localparam logic [1:0] LVL_0 = 2'b00;
    localparam logic [1:0] LVL_1 = 2'b01;
    localparam logic [1:0] LVL_2 = 2'b10;
    localparam logic [1:0] LVL_3 = 2'b11;

    // Strict unsigned compare, thresholds ordered highest first.
    function automatic logic [1:0] level_of(
        input logic [SUM_W-1:0]   sum,
        input logic [THRES_W-1:0] t1,
        input logic [THRES_W-1:0] t2,
        input logic [THRES_W-1:0] t3
    );
        if (sum > {1'b0, t1})
            return LVL_3;
        else if (sum > {1'b0, t2})
            return LVL_2;
        else if (sum > {1'b0, t3})
            return LVL_1;
        else
            return LVL_0;
    endfunction

endpackage

// File: rtl/gaze_level_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request after the last granted index.
// The pointer moves only when the grant is accepted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt,
    output logic [3:0]   gnt_idx
);

    logic [3:0] last;
    logic [3:0] k;
    logic       hit;

    // Scan requests starting just after the last winner, wrapping.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        gnt_idx = last;
        gnt     = '0;
        for (int i = 1; i <= N; i++) begin
            k = 4'((int'(last) + i) % N);
            if (!hit && req[k]) begin
                hit     = 1'b1;
                gnt_idx = k;
            end
        end
        for (int j = 0; j < N; j++)
            gnt[j] = hit && (gnt_idx == 4'(j));
    end

    // Remember the winner; reset makes requester 0 the first choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 4'(N - 1);
        else if (accept)
            last <= gnt_idx;
    end

endmodule

// File: rtl/gaze_level_scheduler.sv
// Schedules per-requester squared-distance jobs and grades the result.
// Optional GAZE_SCHED_LEVEL_TABLE_EN adds o_level_table (last level per id).
module gaze_level_scheduler
    import gaze_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CALC_LAT = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*COORD_W-1:0] i_obs_x,
    input  logic [NUM_REQ*COORD_W-1:0] i_obs_y,
    input  logic [COORD_W-1:0]         i_gaze_x,
    input  logic [COORD_W-1:0]         i_gaze_y,
    input  logic [THRES_W-1:0]         i_thres_1,
    input  logic [THRES_W-1:0]         i_thres_2,
    input  logic [THRES_W-1:0]         i_thres_3,
    output logic                       o_calc_valid,
    output logic [COORD_W-1:0]         o_calc_gaze_x,
    output logic [COORD_W-1:0]         o_calc_gaze_y,
    output logic [COORD_W-1:0]         o_calc_obs_x,
    output logic [COORD_W-1:0]         o_calc_obs_y,
    input  logic [SUM_W-1:0]           i_calc_sum,
    output logic                       o_rsp_valid,
    output logic [3:0]                 o_rsp_id,
    output logic [1:0]                 o_rsp_level
`ifdef GAZE_SCHED_LEVEL_TABLE_EN
    ,
    output logic [2*NUM_REQ-1:0]       o_level_table
`endif
);

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      id_q;
    logic [NUM_REQ-1:0] gnt;
    logic [3:0]      gnt_idx;
    logic            accept;

    assign accept      = (state == ST_IDLE) && (|i_req_valid);
    assign o_req_ready = accept ? gnt : '0;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .req    (i_req_valid),
        .accept (accept),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    // Job FSM: capture, issue, wait out the datapath latency, report.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            id_q          <= '0;
            o_calc_valid  <= 1'b0;
            o_calc_gaze_x <= '0;
            o_calc_gaze_y <= '0;
            o_calc_obs_x  <= '0;
            o_calc_obs_y  <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= '0;
            o_rsp_level   <= LVL_0;
        end else begin
            o_calc_valid <= 1'b0;
            o_rsp_valid  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q          <= gnt_idx;
                        o_calc_gaze_x <= i_gaze_x;
                        o_calc_gaze_y <= i_gaze_y;
                        o_calc_obs_x  <= i_obs_x[int'(gnt_idx)*COORD_W +: COORD_W];
                        o_calc_obs_y  <= i_obs_y[int'(gnt_idx)*COORD_W +: COORD_W];
                        o_calc_valid  <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= 4'(CALC_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        o_rsp_level <= level_of(i_calc_sum, i_thres_1,
                                                i_thres_2, i_thres_3);
                        o_rsp_id    <= id_q;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESULT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESULT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GAZE_SCHED_LEVEL_TABLE_EN
    // Record the reported level against its requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_level_table <= '0;
        else if (state == ST_RESULT)
            o_level_table[int'(o_rsp_id)*2 +: 2] <= o_rsp_level;
    end
`endif

endmodule

// File: tb/tb_gaze_level_scheduler.sv
// Directed bench for gaze_level_scheduler with a latency-3 stub datapath.
// Table vectors plus hand sequences for arbitration and reset.
module tb_gaze_level_scheduler;

    localparam int N   = 4;
    localparam int CW  = 11;
    localparam logic [24:0] GARB = 25'h1FFFFFF;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*CW-1:0] obs_x;
    logic [N*CW-1:0] obs_y;
    logic [CW-1:0] gaze_x;
    logic [CW-1:0] gaze_y;
    logic [23:0]   t1;
    logic [23:0]   t2;
    logic [23:0]   t3;
    logic          calc_valid;
    logic [CW-1:0] c_gx;
    logic [CW-1:0] c_gy;
    logic [CW-1:0] c_ox;
    logic [CW-1:0] c_oy;
    logic [24:0]   calc_sum;
    logic          rsp_valid;
    logic [3:0]    rsp_id;
    logic [1:0]    rsp_level;
`ifdef GAZE_SCHED_LEVEL_TABLE_EN
    logic [2*N-1:0] level_table;
`endif

    int n_chk;
    int n_pass;

    gaze_level_scheduler #(
        .NUM_REQ (N),
        .CALC_LAT(3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_obs_x      (obs_x),
        .i_obs_y      (obs_y),
        .i_gaze_x     (gaze_x),
        .i_gaze_y     (gaze_y),
        .i_thres_1    (t1),
        .i_thres_2    (t2),
        .i_thres_3    (t3),
        .o_calc_valid (calc_valid),
        .o_calc_gaze_x(c_gx),
        .o_calc_gaze_y(c_gy),
        .o_calc_obs_x (c_ox),
        .o_calc_obs_y (c_oy),
        .i_calc_sum   (calc_sum),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_level  (rsp_level)
`ifdef GAZE_SCHED_LEVEL_TABLE_EN
        ,
        .o_level_table(level_table)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub datapath: sum appears only in the third cycle after the strobe.
    int          sd_cnt;
    logic [24:0] sd_val;
    initial begin
        sd_cnt   = 0;
        sd_val   = '0;
        calc_sum = GARB;
    end
    always @(negedge clk) begin
        if (calc_valid) begin
            sd_val   = 25'(((int'(c_gx) - int'(c_ox)) * (int'(c_gx) - int'(c_ox)))
                         + ((int'(c_gy) - int'(c_oy)) * (int'(c_gy) - int'(c_oy))));
            sd_cnt   = 3;
            calc_sum = GARB;
        end else if (sd_cnt > 0) begin
            sd_cnt   = sd_cnt - 1;
            calc_sum = (sd_cnt == 0) ? sd_val : GARB;
        end else begin
            calc_sum = GARB;
        end
    end

    typedef struct {
        int          id;
        logic [10:0] gx;
        logic [10:0] gy;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [23:0] t1;
        logic [23:0] t2;
        logic [23:0] t3;
        logic [1:0]  lvl;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Assumes a negedge in IDLE; runs one job end to end.
    task automatic run_job(input vec_t v);
        int n;
        obs_x = '0;
        obs_y = '0;
        obs_x[v.id*CW +: CW] = v.ox;
        obs_y[v.id*CW +: CW] = v.oy;
        gaze_x    = v.gx;
        gaze_y    = v.gy;
        t1        = v.t1;
        t2        = v.t2;
        t3        = v.t3;
        req_valid = 4'(1 << v.id);
        #1;
        chk("ready", 32'(req_ready), 32'(1 << v.id));
        @(negedge clk);
        req_valid = '0;
        obs_x     = '1;
        obs_y     = '1;
        gaze_x    = 11'h7FF;
        gaze_y    = 11'h000;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd5);
        chk("rsp_id", 32'(rsp_id), 32'(v.id));
        chk("rsp_level", 32'(rsp_level), 32'(v.lvl));
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("id_hold", 32'(rsp_id), 32'(v.id));
        chk("lvl_hold", 32'(rsp_level), 32'(v.lvl));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(rsp_valid), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int g;
        int cyc;
        int prev;
        int bad;
        int n;
        int seen;
        vec_t tv;

        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        obs_x     = '0;
        obs_y     = '0;
        gaze_x    = '0;
        gaze_y    = '0;
        t1        = '0;
        t2        = '0;
        t3        = '0;

        vecs[0] = '{0, 11'd100, 11'd100, 11'd103, 11'd104,
                    24'd1000, 24'd100, 24'd20, 2'b01};
        vecs[1] = '{1, 11'd0, 11'd0, 11'd2047, 11'd2047,
                    24'd8000000, 24'd1000, 24'd10, 2'b11};
        vecs[2] = '{2, 11'd0, 11'd0, 11'd20, 11'd10,
                    24'd500, 24'd300, 24'd100, 2'b10};
        vecs[3] = '{3, 11'd10, 11'd10, 11'd10, 11'd10,
                    24'd5, 24'd3, 24'd0, 2'b00};
        vecs[4] = '{0, 11'd50, 11'd50, 11'd53, 11'd50,
                    24'd100, 24'd50, 24'd9, 2'b00};
        vecs[5] = '{1, 11'd5, 11'd5, 11'd0, 11'd0,
                    24'd1000, 24'd49, 24'd10, 2'b10};

        repeat (2) @(negedge clk);
        chk("rst_calc_valid", 32'(calc_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd0);

        for (int i = 0; i < 6; i++)
            run_job(vecs[i]);

        // All four held: grants 0,1,2,3,0 six cycles apart.
        do_reset();
        for (int i = 0; i < N; i++) begin
            obs_x[i*CW +: CW] = 11'(i);
            obs_y[i*CW +: CW] = 11'(i);
        end
        req_valid = 4'hF;
        g = 0; cyc = 0; prev = 0; bad = 0;
        while (g < 5 && cyc < 100) begin
            #1;
            if ($countones(req_ready) > 1)
                bad++;
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
                if (g > 0)
                    chk("rr_space", 32'(cyc - prev), 32'd6);
                prev = cyc;
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rr_count", 32'(g), 32'd5);
        chk("rr_onehot", 32'(bad), 32'd0);
        req_valid = '0;
        drain();

        // Lone requester is re-granted back-to-back.
        req_valid = 4'b0100;
        g = 0; cyc = 0; prev = 0;
        while (g < 2 && cyc < 50) begin
            #1;
            if (req_ready != '0) begin
                chk("lone_grant", 32'(req_ready), 32'b0100);
                if (g > 0)
                    chk("lone_space", 32'(cyc - prev), 32'd6);
                prev = cyc;
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("lone_count", 32'(g), 32'd2);
        req_valid = '0;
        drain();
        chk("lone_id", 32'(rsp_id), 32'd2);

        // Reset in WAIT abandons the job and restores requester-0 priority.
        req_valid = 4'b0010;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_calc", 32'(calc_valid), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid)
                seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        drain();

`ifdef GAZE_SCHED_LEVEL_TABLE_EN
        do_reset();
        chk("tbl_reset", 32'(level_table), 32'd0);
        tv    = vecs[1];
        run_job(tv);
        tv    = vecs[2];
        tv.id = 3;
        run_job(tv);
        chk("tbl_final", 32'(level_table), 32'b10_00_11_00);
`else
        do_reset();
        tv = vecs[0];
        run_job(tv);
`endif

        n = n_chk;
        $display("%0d/%0d checks passed", n_pass, n);
        $finish;
    end

endmodule

// File: doc/gaze_level_scheduler.md
GAZE_LEVEL_SCHEDULER -- requirements
Module: gaze_level_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of observe-point requesters, range 2..16.
REQ-002 Parameter CALC_LAT, default 3, is the fixed latency in cycles from o_calc_valid to i_calc_sum, range 1..15.
REQ-003 i_clk  in  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_rst_n  in  1  is the reset: asynchronous assert, active-low.
REQ-005 i_req_valid  in  NUM_REQ  carries the per-requester request flags.
REQ-006 o_req_ready  out  NUM_REQ  carries the one-hot grant/accept pulse.
REQ-007 i_obs_x, i_obs_y  in  NUM_REQ*11 each  carry the packed per-requester observe coordinates, with requester k at bits [11k+10:11k].
REQ-008 i_gaze_x, i_gaze_y  in  11 each  carry the gaze centre coordinate.
REQ-009 i_thres_1, i_thres_2, i_thres_3  in  24 each  carry the level thresholds, ordered highest first.
REQ-010 o_calc_valid  out  1  is the issue strobe to the shared squared-distance datapath.
REQ-011 o_calc_gaze_x, o_calc_gaze_y, o_calc_obs_x, o_calc_obs_y  out  11 each  are the latched operands.
REQ-012 i_calc_sum  in  25  is dx^2+dy^2, valid exactly CALC_LAT cycles after o_calc_valid.
REQ-013 o_rsp_valid  out  1, o_rsp_id  out  4, o_rsp_level  out  2  form the result pulse.

Function
REQ-014 The FSM states SHALL be IDLE, ISSUE, WAIT and RESULT.
REQ-015 In IDLE with any i_req_valid bit set, the round-robin grant g (first set bit after the last granted index) SHALL see o_req_ready[g]=1 combinationally in that cycle, operands SHALL be captured (gaze snapshot included), and the FSM SHALL move to ISSUE.
REQ-016 o_req_ready SHALL be all-zero outside IDLE and SHALL never have more than one bit set.
REQ-017 ISSUE: o_calc_valid=1 for exactly one cycle, wait counter loaded with CALC_LAT-1, next state WAIT.
REQ-018 WAIT: the counter decrements each cycle; at 0, i_calc_sum is sampled and compared, next state RESULT.
REQ-019 Compare (strict, unsigned, thresholds zero-extended to 25 bits): sum>thres_1 gives 11, else >thres_2 gives 10, else >thres_3 gives 01, else 00.
REQ-020 RESULT: o_rsp_valid=1 for one cycle with o_rsp_id=g, next state IDLE.
REQ-021 o_rsp_id and o_rsp_level SHALL hold their values after the pulse until the next RESULT.
REQ-022 Latency: accept at cycle 0 gives o_rsp_valid at cycle CALC_LAT+2, and the next accept occurs no earlier than cycle CALC_LAT+3.
REQ-023 Requesters SHALL hold valid until ready; a withdrawn request SHALL cause no grant, and input changes after capture SHALL have no effect.
REQ-024 The round-robin pointer SHALL update only on a grant, and a lone requester SHALL be re-granted back-to-back.

Reset
REQ-025 When i_rst_n is low, the FSM SHALL go to IDLE, the counter SHALL be 0, all outputs SHALL be 0, and the last-grant SHALL be NUM_REQ-1 so that requester 0 has priority.
REQ-026 A reset during ISSUE/WAIT/RESULT SHALL abandon the in-flight job with no o_rsp_valid, and a late i_calc_sum SHALL be ignored.

Configuration
REQ-027 With GAZE_SCHED_LEVEL_TABLE_EN defined, output o_level_table (2*NUM_REQ bits) SHALL store the last level per requester, updated in RESULT and reset to 0.
REQ-028 Without GAZE_SCHED_LEVEL_TABLE_EN, the port and its registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package gaze_sched_pkg SHALL hold the FSM state enum, the level encoding constants (LVL_0..LVL_3), the coordinate width 11, the threshold width 24 and the sum width 25.
REQ-030 Arbitration SHALL be implemented in sub-module rr_arbiter (NUM_REQ-wide request vector in, one-hot grant out, pointer advanced on accept).

Verification
REQ-031 The bench SHALL use a stub datapath with latency 3.
REQ-032 Single request: req0, gaze(100,100), obs(103,104), thresholds 1000/100/20 -> sum 25, o_rsp_level=01, id 0, rsp at cycle 5 after accept.
REQ-033 All four requests held continuously -> grants in order 0,1,2,3,0, each spaced 6 cycles, with exactly one ready bit per grant.
REQ-034 Boundary: sum==thres_1==500 -> level 10 (strict compare); gaze(0,0) with obs(2047,2047) -> sum 8380418, level 11 with thres_1=8000000.
REQ-035 i_rst_n pulsed low in WAIT -> no rsp, state IDLE, and req0 is granted first after release.
REQ-036 Build with GAZE_SCHED_LEVEL_TABLE_EN -> after requests to ids 1 and 3, o_level_table holds their levels and zeros elsewhere; without the macro, the REQ-032 results are unchanged.
